// File: rtl/sca_next_block_sel.sv
// SCA next-block selector: tracks which of the 16 SCA storage blocks are free,
// picks the free block nearest (in Hamming order) to RDADR on each NBSEL strobe,
// flags SCA-full and maintains a free-block counter.
// Optional build macro NBSEL_BMEM_EN exposes the occupancy map on BMEM.
// Parameter TMR=1 triplicates every state register behind a bitwise majority vote.
module sca_next_block_sel #(
  parameter int unsigned TMR       = 0,
  parameter int unsigned FREE_INIT = 9
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WRENA,
  input  logic        SELA,
  input  logic        NBSEL,
  input  logic [3:0]  BADR,
  input  logic [3:0]  RDADR,
  output logic [3:0]  NADR,
  output logic [15:0] BMEM,
  output logic [3:0]  NFREE_BLKS,
  output logic        SCAFULL
);

  localparam int unsigned ADR_W  = 4;
  localparam int unsigned N_CAND = 15;

  // Hamming-order neighbour masks, M[0] in the least significant nibble:
  // single-bit flips first, then two-bit, three-bit and finally all four bits.
  localparam logic [N_CAND*ADR_W-1:0] MASK_TAB = {
    4'hF, 4'hE, 4'hD, 4'hB, 4'h7, 4'hC, 4'hA, 4'h9,
    4'h6, 4'h5, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1
  };

  // Complete state of the block, so redundancy is applied in one place.
  typedef struct packed {
    logic [15:0] map;      // 1 = block free
    logic [3:0]  nadr;
    logic        scafull;
    logic [3:0]  nfree;
    logic        dwr;      // delayed write strobe
    logic        ddat;     // delayed written map bit
    logic        dsel;     // delayed SELA
    logic        dfull;    // delayed SCAFULL
    logic        sf_clr;   // suppress SCAFULL until first NBSEL after reset
  } st_t;

  localparam st_t ST_RST = '{
    map:     16'h55FF,
    nadr:    4'h0,
    scafull: 1'b0,
    nfree:   4'(FREE_INIT),
    dwr:     1'b0,
    ddat:    1'b0,
    dsel:    1'b0,
    dfull:   1'b0,
    sf_clr:  1'b1
  };

  st_t               st_q;
  st_t               st_d;
  logic [N_CAND-1:0] cand_c;
  logic [3:0]        sel_nadr_c;
  logic              wdat_c;

  // Candidate vector and lowest-index free neighbour (falls back to ~RDADR).
  always_comb begin
    cand_c     = '0;
    sel_nadr_c = ~RDADR;
    for (int k = 0; k < N_CAND; k++) begin
      cand_c[k] = st_q.map[RDADR ^ MASK_TAB[k*ADR_W +: ADR_W]];
    end
    for (int k = N_CAND - 1; k >= 0; k--) begin
      if (cand_c[k]) sel_nadr_c = RDADR ^ MASK_TAB[k*ADR_W +: ADR_W];
    end
  end

  // Odd addresses in the upper half (9, 11, 13, 15) can never be released.
  always_comb begin
    wdat_c = SELA ? 1'b0 : ~(BADR[3] & BADR[0]);
  end

  // Next-state: map write, next-block select, delay pipeline and counter.
  always_comb begin
    st_d = st_q;

    if (WRENA) st_d.map[BADR] = wdat_c;

    if (NBSEL) begin
      st_d.nadr    = sel_nadr_c;
      st_d.scafull = st_q.sf_clr ? 1'b0 : ~|cand_c;
      st_d.sf_clr  = 1'b0;
    end

    st_d.dwr   = WRENA;
    st_d.ddat  = wdat_c;
    st_d.dsel  = SELA;
    st_d.dfull = st_q.scafull;

    // Allocations issued while full were not real allocations; skip them.
    if (st_q.dwr && !(st_q.dsel && st_q.dfull)) begin
      if (st_q.ddat) begin
        if (st_q.nfree != 4'hF) st_d.nfree = st_q.nfree + 4'd1;
      end else begin
        if (st_q.nfree != 4'h0) st_d.nfree = st_q.nfree - 4'd1;
      end
    end
  end

  generate
    if (TMR != 0) begin : g_tmr
      st_t st_a_q, st_b_q, st_c_q;

      // Three independent copies of the state.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          st_a_q <= ST_RST;
          st_b_q <= ST_RST;
          st_c_q <= ST_RST;
        end else begin
          st_a_q <= st_d;
          st_b_q <= st_d;
          st_c_q <= st_d;
        end
      end

      // Bitwise majority vote feeds both outputs and next-state logic.
      assign st_q = st_t'((st_a_q & st_b_q) | (st_a_q & st_c_q) | (st_b_q & st_c_q));
    end else begin : g_single
      // Single state register.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) st_q <= ST_RST;
        else        st_q <= st_d;
      end
    end
  endgenerate

  assign NADR       = st_q.nadr;
  assign SCAFULL    = st_q.scafull;
  assign NFREE_BLKS = st_q.nfree;

`ifdef NBSEL_BMEM_EN
  assign BMEM = st_q.map;
`else
  assign BMEM = 16'h0000;
`endif

endmodule

// File: tb/tb_sca_next_block_sel.sv
// Scoreboard bench for sca_next_block_sel: stimulus pushes hand-computed
// expectations, a monitor pops and compares them against the DUT outputs.
module tb_sca_next_block_sel;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        WRENA, SELA, NBSEL;
  logic [3:0]  BADR, RDADR;
  logic [3:0]  NADR;
  logic [15:0] BMEM;
  logic [3:0]  NFREE_BLKS;
  logic        SCAFULL;

  typedef struct {
    string       name;
    logic [3:0]  nadr;
    logic        sf;
    logic [3:0]  nf;
    logic [15:0] map;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   n_vec = 0;
  int   n_err = 0;

  sca_next_block_sel #(.TMR(0), .FREE_INIT(9)) dut (
    .CLK(CLK), .RST_N(RST_N), .WRENA(WRENA), .SELA(SELA), .NBSEL(NBSEL),
    .BADR(BADR), .RDADR(RDADR), .NADR(NADR), .BMEM(BMEM),
    .NFREE_BLKS(NFREE_BLKS), .SCAFULL(SCAFULL)
  );

  always #5 CLK = ~CLK;

  // Called right after a falling edge: hold inputs over one rising edge.
  task automatic step(input logic wr, input logic sel, input logic nb,
                      input logic [3:0] badr, input logic [3:0] rdadr);
    WRENA = wr; SELA = sel; NBSEL = nb; BADR = badr; RDADR = rdadr;
    @(posedge CLK);
    @(negedge CLK);
    WRENA = 1'b0; NBSEL = 1'b0;
  endtask

  task automatic exp_push(input string name, input logic [3:0] nadr, input logic sf,
                          input logic [3:0] nf, input logic [15:0] map);
    exp_t e;
    e.name = name; e.nadr = nadr; e.sf = sf; e.nf = nf; e.map = map;
    sb_q.push_back(e);
    -> chk_ev;
  endtask

  // Monitor: compare every queued expectation against current outputs.
  initial begin
    exp_t        e;
    logic [15:0] exp_bmem;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
`ifdef NBSEL_BMEM_EN
        exp_bmem = e.map;
`else
        exp_bmem = 16'h0000;
`endif
        if (NADR !== e.nadr) begin
          n_err++; $display("FAIL %s NADR got %h exp %h", e.name, NADR, e.nadr);
        end
        if (SCAFULL !== e.sf) begin
          n_err++; $display("FAIL %s SCAFULL got %b exp %b", e.name, SCAFULL, e.sf);
        end
        if (NFREE_BLKS !== e.nf) begin
          n_err++; $display("FAIL %s NFREE_BLKS got %0d exp %0d", e.name, NFREE_BLKS, e.nf);
        end
        if (BMEM !== exp_bmem) begin
          n_err++; $display("FAIL %s BMEM got %h exp %h", e.name, BMEM, exp_bmem);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] alloc_list [11];
    alloc_list = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hE};

    RST_N = 1'b0; WRENA = 1'b0; SELA = 1'b0; NBSEL = 1'b0; BADR = 4'h0; RDADR = 4'h0;
    @(negedge CLK); @(negedge CLK);
    exp_push("reset", 4'h0, 1'b0, 4'd9, 16'h55FF);
    RST_N = 1'b1;

    // 1: first select after reset; SCAFULL suppressed.
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    exp_push("nb_first", 4'h1, 1'b0, 4'd9, 16'h55FF);

    // 2: allocate block 1, then select; count lags two edges.
    step(1'b1, 1'b1, 1'b0, 4'h1, 4'h0);
    exp_push("alloc1", 4'h1, 1'b0, 4'd9, 16'h55FD);
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    exp_push("nb_after_alloc1", 4'h2, 1'b0, 4'd8, 16'h55FD);

    // 3: release block 1, then select.
    step(1'b1, 1'b0, 1'b0, 4'h1, 4'h0);
    exp_push("rel1", 4'h2, 1'b0, 4'd8, 16'h55FF);
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    exp_push("nb_after_rel1", 4'h1, 1'b0, 4'd9, 16'h55FF);

    // 4: allocate every free neighbour of block 0 -> full, counter floors at 0.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b1, 1'b0, alloc_list[i], 4'h0);
      if (i == 4) exp_push("alloc5", 4'h1, 1'b0, 4'd5, 16'h55C1);
    end
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    exp_push("full", 4'hF, 1'b1, 4'd0, 16'h0001);

    // 5: counting while full, simultaneous write+select, release of 3.
    step(1'b1, 1'b0, 1'b0, 4'hA, 4'h0);
    exp_push("relA", 4'hF, 1'b1, 4'd0, 16'h0401);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    exp_push("alloc0_full", 4'hF, 1'b1, 4'd1, 16'h0400);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    exp_push("no_count_full", 4'hF, 1'b1, 4'd1, 16'h0400);
    step(1'b1, 1'b0, 1'b1, 4'h3, 4'h0);
    exp_push("simul_wr_nb", 4'hA, 1'b0, 4'd1, 16'h0408);
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    exp_push("nb_rel3", 4'h3, 1'b0, 4'd2, 16'h0408);

    // Block 9 can never be released; the write still counts down.
    step(1'b1, 1'b0, 1'b0, 4'h9, 4'h0);
    exp_push("rel9", 4'h3, 1'b0, 4'd2, 16'h0408);
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h9);
    exp_push("nb_rd9", 4'hA, 1'b0, 4'd1, 16'h0408);

    // Counter saturates at 15 under repeated releases.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
      if (i == 13) exp_push("sat14", 4'hA, 1'b0, 4'd14, 16'h0409);
    end
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    exp_push("sat15", 4'hA, 1'b0, 4'd15, 16'h0409);

    // 6: asynchronous reset between clock edges.
    #2;
    RST_N = 1'b0;
    #1;
    exp_push("rst_async", 4'h0, 1'b0, 4'd9, 16'h55FF);
    @(negedge CLK);
    RST_N = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    exp_push("nb_after_rst", 4'h1, 1'b0, 4'd9, 16'h55FF);

    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left %0d entries exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
